// File: rtl/ip_rx_if.sv
// rtl/ip_rx_if.sv - MAC-side input stream and IP payload/metadata outputs of ip_rx
interface ip_rx_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 2
) ();
   logic              cancel_i;
   logic              valid_i;
   logic              start_i;
   logic [DATA_W-1:0] data_i;
   logic [LEN_W-1:0]  len_i;

   logic              valid_o;
   logic              start_o;
   logic              last_o;
   logic [DATA_W-1:0] data_o;
   logic [LEN_W-1:0]  len_o;
   logic              meta_v_o;
   logic [7:0]        protocol_o;
   logic [31:0]       src_addr_o;
   logic [31:0]       dst_addr_o;
   logic              hdr_err_o;
   logic              trunc_err_o;

   modport master (
      output cancel_i, valid_i, start_i, data_i, len_i,
      input  valid_o, start_o, last_o, data_o, len_o, meta_v_o,
             protocol_o, src_addr_o, dst_addr_o, hdr_err_o, trunc_err_o
   );

   modport slave (
      input  cancel_i, valid_i, start_i, data_i, len_i,
      output valid_o, start_o, last_o, data_o, len_o, meta_v_o,
             protocol_o, src_addr_o, dst_addr_o, hdr_err_o, trunc_err_o
   );
endinterface

// File: rtl/ip_rx.sv
// rtl/ip_rx.sv - IPv4 header parser/validator forwarding payload beats of a 16-bit MAC stream
module ip_rx #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 2
) (
   input  logic   clk,
   input  logic   nreset,
   ip_rx_if.slave bus
);
   localparam int BYTES = DATA_W / 8;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      HEAD = 4'b0010,
      DATA = 4'b0100,
      DROP = 4'b1000
   } state_t;

   state_t state_q, state_d;
   logic [5:0]  hcnt_q, hcnt_d;
   logic [3:0]  ihl_q, ihl_d;
   logic [15:0] tlen_q, tlen_d;
   logic [15:0] remain_q, remain_d;
   logic [15:0] csum_q, csum_d;
   logic        bad_q, bad_d;
   logic        first_q, first_d;
   logic [7:0]  proto_p_q, proto_p_d;
   logic [31:0] src_p_q, src_p_d;
   logic [31:0] dst_p_q, dst_p_d;

   logic              valid_q, valid_d;
   logic              start_q, start_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              meta_q, meta_d;
   logic [7:0]        proto_q, proto_d;
   logic [31:0]       src_q, src_d;
   logic [31:0]       dst_q, dst_d;
   logic              hdr_err_q, hdr_err_d;
   logic              trunc_q, trunc_d;

   logic [7:0]  b0, b1;
   logic [15:0] word;
   logic [16:0] sum_full;
   logic [15:0] sum_fold;
   logic [5:0]  hdr_end;
   logic [15:0] len16;

   // Wire byte 0 sits in [7:0]; header words are big-endian on the wire.
   assign b0       = bus.data_i[7:0];
   assign b1       = bus.data_i[15:8];
   assign word     = {b0, b1};
   assign sum_full = {1'b0, csum_q} + {1'b0, word};
   assign sum_fold = sum_full[15:0] + {15'd0, sum_full[16]};
   assign len16    = 16'(bus.len_i);
   // A bogus IHL still gets judged after the minimum 20-byte header.
   assign hdr_end  = (ihl_q < 4'd5) ? 6'd20 : {ihl_q, 2'b00};

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      ihl_d     = ihl_q;
      tlen_d    = tlen_q;
      remain_d  = remain_q;
      csum_d    = csum_q;
      bad_d     = bad_q;
      first_d   = first_q;
      proto_p_d = proto_p_q;
      src_p_d   = src_p_q;
      dst_p_d   = dst_p_q;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      last_d    = 1'b0;
      data_d    = data_q;
      len_d     = len_q;
      meta_d    = 1'b0;
      proto_d   = proto_q;
      src_d     = src_q;
      dst_d     = dst_q;
      hdr_err_d = 1'b0;
      trunc_d   = 1'b0;

      if (bus.cancel_i) begin
         state_d = IDLE;
      end else if (bus.valid_i && bus.start_i) begin
         trunc_d = (state_q == HEAD) || (state_q == DATA);
         state_d = HEAD;
         hcnt_d  = 6'd2;
         ihl_d   = b0[3:0];
         csum_d  = word;
         bad_d   = (b0[7:4] != 4'd4) || (len16 != 16'(BYTES));
         first_d = 1'b0;
      end else if (bus.valid_i) begin
         case (state_q)
            HEAD: begin
               hcnt_d = hcnt_q + 6'd2;
               csum_d = sum_fold;
               if (len16 != 16'(BYTES)) bad_d = 1'b1;
               case (hcnt_q)
                  6'd2:  tlen_d = word;
                  6'd6:  if (word[13] || (word[12:0] != 13'd0)) bad_d = 1'b1;
                  6'd8:  proto_p_d = b1;
                  6'd12: src_p_d[31:16] = word;
                  6'd14: src_p_d[15:0] = word;
                  6'd16: dst_p_d[31:16] = word;
                  6'd18: dst_p_d[15:0] = word;
                  default: ;
               endcase
               if (hcnt_d == hdr_end) begin
                  if (bad_d || (ihl_q < 4'd5) || (tlen_d < {10'd0, ihl_q, 2'b00}) ||
                      (sum_fold != 16'hFFFF)) begin
                     hdr_err_d = 1'b1;
                     state_d   = DROP;
                  end else begin
                     meta_d   = 1'b1;
                     proto_d  = proto_p_d;
                     src_d    = src_p_d;
                     dst_d    = dst_p_d;
                     remain_d = tlen_d - {10'd0, ihl_q, 2'b00};
                     first_d  = 1'b1;
                     state_d  = (remain_d == 16'd0) ? IDLE : DATA;
                  end
               end
            end
            DATA: begin
               valid_d = 1'b1;
               data_d  = bus.data_i;
               start_d = first_q;
               first_d = 1'b0;
               if (len16 >= remain_q) begin
                  last_d  = 1'b1;
                  len_d   = remain_q[LEN_W-1:0];
                  state_d = IDLE;
               end else if (len16 < 16'(BYTES)) begin
                  last_d  = 1'b1;
                  len_d   = bus.len_i;
                  trunc_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  len_d    = bus.len_i;
                  remain_d = remain_q - len16;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q   <= IDLE;
         hcnt_q    <= '0;
         ihl_q     <= '0;
         tlen_q    <= '0;
         remain_q  <= '0;
         csum_q    <= '0;
         bad_q     <= 1'b0;
         first_q   <= 1'b0;
         proto_p_q <= '0;
         src_p_q   <= '0;
         dst_p_q   <= '0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         last_q    <= 1'b0;
         data_q    <= '0;
         len_q     <= '0;
         meta_q    <= 1'b0;
         proto_q   <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         hdr_err_q <= 1'b0;
         trunc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         ihl_q     <= ihl_d;
         tlen_q    <= tlen_d;
         remain_q  <= remain_d;
         csum_q    <= csum_d;
         bad_q     <= bad_d;
         first_q   <= first_d;
         proto_p_q <= proto_p_d;
         src_p_q   <= src_p_d;
         dst_p_q   <= dst_p_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         last_q    <= last_d;
         data_q    <= data_d;
         len_q     <= len_d;
         meta_q    <= meta_d;
         proto_q   <= proto_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         hdr_err_q <= hdr_err_d;
         trunc_q   <= trunc_d;
      end
   end

   assign bus.valid_o     = valid_q;
   assign bus.start_o     = start_q;
   assign bus.last_o      = last_q;
   assign bus.data_o      = data_q;
   assign bus.len_o       = len_q;
   assign bus.meta_v_o    = meta_q;
   assign bus.protocol_o  = proto_q;
   assign bus.src_addr_o  = src_q;
   assign bus.dst_addr_o  = dst_q;
   assign bus.hdr_err_o   = hdr_err_q;
   assign bus.trunc_err_o = trunc_q;
endmodule

// File: doc/ip_rx.md
IP_RX -- requirements
Module: ip_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the stream width in bits; 16 is the only supported value.
REQ-002 The block SHALL have parameter LEN_W, default 2, meaning the width of the byte-count fields.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 nreset  input  1  reset, synchronous, active-low.
REQ-005 cancel_i  input  1  abort the current packet (PHY or MAC error).
REQ-006 valid_i  input  1  MAC beat valid.
REQ-007 start_i  input  1  first beat after the MAC header (the beat where the MAC marks start).
REQ-008 data_i  input  16  MAC payload; [7:0] is the first wire byte.
REQ-009 len_i  input  2  valid bytes in data_i (1 or 2); valid bytes are LSB-aligned.
REQ-010 valid_o  output  1  payload beat valid.
REQ-011 start_o  output  1  first payload beat.
REQ-012 last_o  output  1  final payload beat.
REQ-013 data_o  output  16  payload, same byte order as data_i.
REQ-014 len_o  output  2  valid bytes in data_o.
REQ-015 meta_v_o  output  1  one-cycle pulse: header accepted.
REQ-016 protocol_o  output  8  IPv4 protocol field.
REQ-017 src_addr_o  output  32  source address; [31:24] is the first wire byte.
REQ-018 dst_addr_o  output  32  destination address, same byte order as src_addr_o.
REQ-019 hdr_err_o  output  1  one-cycle pulse: header rejected.
REQ-020 trunc_err_o  output  1  one-cycle pulse: packet ended before total length.

Function
REQ-021 FSM states SHALL be IDLE, HEAD, DATA, DROP (one-hot); all outputs registered, 1-cycle latency from the input beat.
REQ-022 Precedence SHALL be: cancel_i → IDLE (highest); then valid_i & start_i in any state → HEAD with header byte count 2; otherwise state advances only on valid_i.
REQ-023 A start_i beat arriving in HEAD or DATA SHALL pulse trunc_err_o and restart header parsing on that beat.
REQ-024 HEAD SHALL consume 2 bytes per beat; header byte offsets: 0 version/IHL, 2-3 total length, 6-7 flags/fragment offset, 9 protocol, 10-11 checksum, 12-15 src, 16-19 dst, 20..IHL*4-1 options (skipped).
REQ-025 The checksum SHALL be a 16-bit ones-complement sum with end-around carry over all IHL*2 words, each word formed as {data_i[7:0], data_i[15:8]}; a header passes when the final sum equals 16'hFFFF.
REQ-026 The header SHALL be rejected if any of: version != 4; IHL < 5; total length < IHL*4; MF flag set; fragment offset != 0; len_i != 2 on a header beat; checksum fails.
REQ-027 On the final header beat (byte count == IHL*4): on reject, pulse hdr_err_o and → DROP; on accept, pulse meta_v_o, update protocol_o/src_addr_o/dst_addr_o, load remain = total length - IHL*4, → DATA (or IDLE if remain == 0).
REQ-028 protocol_o, src_addr_o and dst_addr_o SHALL hold their values until the next meta_v_o.
REQ-029 In DATA, each valid beat SHALL be forwarded; start_o is set on the first forwarded beat; if len_i >= remain then last_o=1, len_o=remain and the state → IDLE; otherwise len_o=len_i and remain -= len_i.
REQ-030 In DATA, a beat with len_i < 2 and len_i < remain SHALL be forwarded with last_o=1, pulse trunc_err_o, and → IDLE.
REQ-031 Trailing bytes (Ethernet padding, FCS) arriving in IDLE or DROP SHALL be discarded; DROP exits only on start_i or cancel_i.
REQ-032 remain SHALL be 16 bits, the header byte counter 6 bits, and the checksum accumulator 17 bits before folding.

Reset
REQ-033 While nreset=0: state IDLE; valid_o, start_o, last_o, meta_v_o, hdr_err_o, trunc_err_o = 0; data_o, len_o, protocol_o, src_addr_o, dst_addr_o = 0; counters and accumulator = 0.
REQ-034 Reset asserted mid-packet SHALL discard the packet; no error pulse is generated.

Verification
REQ-035 Header 45 00 00 1E 00 00 40 00 40 11 B9 7B C0 A8 00 01 C0 A8 00 02, then 10 payload bytes and 4 FCS bytes → meta_v_o pulse with protocol_o=0x11, src_addr_o=0xC0A80001, dst_addr_o=0xC0A80002; 5 valid_o beats, start_o on the first, last_o with len_o=2 on the fifth; FCS not forwarded.
REQ-036 Same packet with checksum B9 7C → hdr_err_o pulse, no valid_o, DROP until the next start_i.
REQ-037 Total length 0x001D with checksum B9 7C → 5 beats, last beat len_o=1.
REQ-038 First byte 0x65 (version 6) → hdr_err_o, no meta_v_o; first byte 0x46 (IHL 6) with a valid checksum → 4 option bytes skipped, payload correct.
REQ-039 cancel_i on the 3rd payload beat → no further valid_o; the next start_i packet is parsed normally.
REQ-040 start_i on the 2nd payload beat → trunc_err_o pulse and new header parsed; nreset=0 mid-DATA → all outputs 0 next cycle.
